// File: rtl/addsub_pkg.sv
// Shared helpers for the add/sub pipeline: half-width split and saturation limits.
package addsub_pkg;

   localparam int MAX_W = 64;

   function automatic int lo_w(input int w);
      return w / 2;
   endfunction

   function automatic int hi_w(input int w);
      return w - (w / 2);
   endfunction

   // Limits come back MAX_W wide; callers keep the low w bits.
   function automatic logic [MAX_W-1:0] sat_max(input int w, input logic is_signed);
      logic [MAX_W-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if ((i < w - 1) || ((i == w - 1) && !is_signed)) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [MAX_W-1:0] sat_min(input int w, input logic is_signed);
      logic [MAX_W-1:0] m;
      m = '0;
      if (is_signed) m[w-1] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// N-bit ripple-carry adder slice; the pipeline splits the word into two of these.
module addsub_slice #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   always_comb begin
      logic [N:0] c;
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < N; i++) begin
         sum[i]  = a[i] ^ b[i] ^ c[i];
         c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[N];
   end

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage carry-split adder/subtractor with optional saturation, flags and
// valid/ready handshake on both sides.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             signed_mode,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int LO = lo_w(WIDTH);
   localparam int HI = hi_w(WIDTH);
   localparam logic [MAX_W-1:0] SMAX_F = sat_max(WIDTH, 1'b1);
   localparam logic [MAX_W-1:0] SMIN_F = sat_min(WIDTH, 1'b1);
   localparam logic [WIDTH-1:0] SMAX   = SMAX_F[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SMIN   = SMIN_F[WIDTH-1:0];

   if ((WIDTH % 2 != 0) || (WIDTH < 4) || (WIDTH > MAX_W)) begin : g_bad_width
      $error("addsub_pipe: WIDTH must be even and within 4..64");
   end

   logic             s1_valid;
   logic [LO-1:0]    s1_lo;
   logic             s1_clo;
   logic [HI-1:0]    s1_ahi;
   logic [HI-1:0]    s1_ehi;
   logic             s1_sub;
   logic             s1_sm;
   logic             s1_sat;

   logic [WIDTH-1:0] e;
   logic [LO-1:0]    lo_sum;
   logic             lo_cout;
   logic [HI-1:0]    hi_sum;
   logic             hi_cout;
   logic [WIDTH-1:0] raw;
   logic             raw_ovf;
   logic [WIDTH-1:0] fin;
   logic             s2_adv;

   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;
   assign e        = b ^ {WIDTH{sub}};

   addsub_slice #(.N(LO)) u_lo (
      .a    (a[LO-1:0]),
      .b    (e[LO-1:0]),
      .cin  (sub),
      .sum  (lo_sum),
      .cout (lo_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_lo    <= '0;
         s1_clo   <= 1'b0;
         s1_ahi   <= '0;
         s1_ehi   <= '0;
         s1_sub   <= 1'b0;
         s1_sm    <= 1'b0;
         s1_sat   <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_lo  <= lo_sum;
            s1_clo <= lo_cout;
            s1_ahi <= a[WIDTH-1:LO];
            s1_ehi <= e[WIDTH-1:LO];
            s1_sub <= sub;
            s1_sm  <= signed_mode;
            s1_sat <= sat;
         end
      end
   end

   addsub_slice #(.N(HI)) u_hi (
      .a    (s1_ahi),
      .b    (s1_ehi),
      .cin  (s1_clo),
      .sum  (hi_sum),
      .cout (hi_cout)
   );

   assign raw     = {hi_sum, s1_lo};
   assign raw_ovf = (s1_ahi[HI-1] == s1_ehi[HI-1]) && (raw[WIDTH-1] != s1_ahi[HI-1]);

   // Signed clamp follows the sign of A; unsigned clamp follows the carry/borrow.
   always_comb begin
      fin = raw;
      if (s1_sat) begin
         if (s1_sm) begin
            if (raw_ovf) fin = s1_ahi[HI-1] ? SMIN : SMAX;
         end else if (!s1_sub && hi_cout) begin
            fin = '1;
         end else if (s1_sub && !hi_cout) begin
            fin = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result <= fin;
            cout   <= hi_cout;
            ovf    <= raw_ovf;
            zero   <= (fin == '0);
            neg    <= fin[WIDTH-1];
         end
      end
   end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: a 16-bit and an 8-bit instance share stimulus and handshake.
module tb_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, sub, signed_mode, sat, out_ready;
   logic [15:0] a, b;
   logic        in_ready, out_valid, cout, ovf, zero, neg;
   logic [15:0] result;
   logic        in_ready8, out_valid8, cout8, ovf8, zero8, neg8;
   logic [7:0]  result8;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   addsub_pipe #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .signed_mode(signed_mode), .sat(sat),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
   );

   addsub_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
      .a(a[7:0]), .b(b[7:0]), .sub(sub), .signed_mode(signed_mode), .sat(sat),
      .out_valid(out_valid8), .out_ready(out_ready), .result(result8),
      .cout(cout8), .ovf(ovf8), .zero(zero8), .neg(neg8)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic        sm;
      logic        sat;
      logic [15:0] r;
      logic [3:0]  f;
      logic [7:0]  r8;
      logic [3:0]  f8;
   } vec_t;

   typedef struct packed {
      logic [15:0] r;
      logic [3:0]  f;
      logic [7:0]  r8;
      logic [3:0]  f8;
   } exp_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Reference: true integer arithmetic, then the clamp rules; flags {cout, ovf, zero, neg}.
   function automatic void model(input int w, input longint ua, input longint ub,
                                 input bit s, input bit sm, input bit st,
                                 output longint res, output logic [3:0] fl);
      longint mask, half, sa, sb, full, tv;
      bit co, ov;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      sa   = (ua >= half) ? ua - 2 * half : ua;
      sb   = (ub >= half) ? ub - 2 * half : ub;
      full = s ? ua + ((~ub) & mask) + 1 : ua + ub;
      tv   = s ? sa - sb : sa + sb;
      co   = full > mask;
      ov   = (tv > half - 1) || (tv < -half);
      res  = full & mask;
      if (st) begin
         if (sm) begin
            if (ov) res = (tv > 0) ? half - 1 : half;
         end else if (!s && co) begin
            res = mask;
         end else if (s && !co) begin
            res = 0;
         end
      end
      fl = {co, ov, res == 0, res >= half};
   endfunction

   task automatic apply_vec(input vec_t v, input string name);
      int lat;
      @(negedge clk);
      a = v.a; b = v.b; sub = v.sub; signed_mode = v.sm; sat = v.sat;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk({name, " in_ready idle"}, in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk({name, " latency"}, lat, 2);
      chk({name, " w16"}, {result, cout, ovf, zero, neg}, {v.r, v.f});
      chk({name, " w8"}, {out_valid8, result8, cout8, ovf8, zero8, neg8}, {1'b1, v.r8, v.f8});
   endtask

   task automatic run_stream(input int nbeats, input bit counting, input string name);
      exp_t q[$];
      exp_t ex;
      int pushed, popped, cyc, inflight;
      longint r;
      logic [3:0] fl;
      bit exp_ready;
      pushed = 0; popped = 0; cyc = 0;
      while (popped < nbeats && cyc < 4000) begin
         @(negedge clk);
         if (counting) begin
            out_ready = (cyc % 3 == 0);
            in_valid  = (pushed < nbeats);
            a = 16'(pushed); b = 16'd1; sub = 1'b0; signed_mode = 1'b0; sat = 1'b0;
         end else begin
            out_ready   = ($urandom_range(0, 3) != 0);
            in_valid    = (pushed < nbeats) && ($urandom_range(0, 2) != 0);
            a           = 16'($urandom);
            b           = 16'($urandom);
            sub         = 1'($urandom);
            signed_mode = 1'($urandom);
            sat         = 1'($urandom);
         end
         #1;
         inflight  = pushed - popped;
         exp_ready = !((inflight == 2) && !out_ready);
         chk({name, " in_ready"}, {in_ready, in_ready8}, {exp_ready, exp_ready});
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk({name, " spurious output"}, {out_valid, result}, 17'h0);
            end else begin
               ex = q.pop_front();
               chk({name, " result"}, {result, cout, ovf, zero, neg, out_valid8, result8, cout8, ovf8, zero8, neg8},
                   {ex.r, ex.f, 1'b1, ex.r8, ex.f8});
            end
            popped++;
         end
         if (in_valid && in_ready) begin
            model(16, longint'(a), longint'(b), sub, signed_mode, sat, r, fl);
            ex.r = 16'(r); ex.f = fl;
            model(8, longint'(a[7:0]), longint'(b[7:0]), sub, signed_mode, sat, r, fl);
            ex.r8 = 8'(r); ex.f8 = fl;
            q.push_back(ex);
            pushed++;
         end
         cyc++;
      end
      chk({name, " beats out"}, popped, nbeats);
      chk({name, " queue drained"}, q.size(), 0);
      in_valid = 1'b0;
      @(negedge clk);
      chk({name, " no duplicate"}, {out_valid, out_valid8}, 2'b00);
   endtask

   initial begin
      //          a         b         sub   sm    sat   r         f        r8     f8
      vecs[0]  = '{16'h0003, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b0010, 8'h00, 4'b0010};
      vecs[1]  = '{16'hFFF0, 16'h0020, 1'b0, 1'b0, 1'b1, 16'hFFFF, 4'b1001, 8'hFF, 4'b1001};
      vecs[2]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 4'b0000, 8'h00, 4'b1010};
      vecs[3]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1010, 8'h00, 4'b1010};
      vecs[4]  = '{16'h0100, 16'h00FF, 1'b0, 1'b0, 1'b0, 16'h01FF, 4'b0000, 8'hFF, 4'b0001};
      vecs[5]  = '{16'h7070, 16'h2020, 1'b0, 1'b1, 1'b1, 16'h7FFF, 4'b0100, 8'h7F, 4'b0100};
      vecs[6]  = '{16'h7070, 16'h2020, 1'b0, 1'b1, 1'b0, 16'h9090, 4'b0101, 8'h90, 4'b0101};
      vecs[7]  = '{16'h0505, 16'h0303, 1'b1, 1'b0, 1'b0, 16'h0202, 4'b1000, 8'h02, 4'b1000};
      vecs[8]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h8000, 4'b1101, 8'hFF, 4'b0001};
      vecs[9]  = '{16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0, 16'hFFFE, 4'b0001, 8'hFE, 4'b0001};
      vecs[10] = '{16'h7000, 16'h2000, 1'b0, 1'b0, 1'b1, 16'h9000, 4'b0101, 8'h00, 4'b0010};
      vecs[11] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0000, 4'b1010, 8'h00, 4'b1010};
      vecs[12] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1, 16'h8000, 4'b1101, 8'h00, 4'b0010};
      vecs[13] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b1010, 8'h00, 4'b1010};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; sub = 1'b0; signed_mode = 1'b0; sat = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset state", {in_ready, out_valid, result, cout, ovf, zero, neg}, {1'b1, 1'b0, 16'h0, 4'h0});
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

      // Fill both stages under a stall, then reset mid-flight.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; a = 16'h0011; b = 16'h0001;
      sub = 1'b0; signed_mode = 1'b0; sat = 1'b0;
      @(posedge clk);
      @(negedge clk);
      a = 16'h0022;
      #1;
      chk("second beat accepted", in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("full stall", {in_ready, out_valid, result}, {1'b0, 1'b1, 16'h0012});
      rst_n = 1'b0;
      #1;
      chk("async reset", {in_ready, out_valid, result, cout, ovf, zero, neg,
                          in_ready8, out_valid8, result8, cout8, ovf8, zero8, neg8},
          {1'b1, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 8'h0, 4'h0});
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("no stale output", {out_valid, out_valid8}, 2'b00);
      end
      apply_vec('{16'h0100, 16'h00FF, 1'b0, 1'b0, 1'b0, 16'h01FF, 4'b0000, 8'hFF, 4'b0001}, "post-reset");

      run_stream(10, 1'b1, "backpressure");
      run_stream(300, 1'b0, "random");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised two-stage pipelined adder/subtractor for the speed-error datapath of the cruise controller. It takes the place of the fixed 8-bit ripple add/sub unit: any even width, a carry-split pipeline, and optional saturation. It also produces carry, signed overflow, zero and negative flags. A valid/ready handshake on both sides lets it sit between the sensor sampler and the PI controller with full backpressure.

## Interface
- WIDTH, 16, operand/result width; even, ≥ 4; LO = WIDTH/2, HI = WIDTH − LO
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous assertion, active-low
- in_valid  in  1  operand beat offered
- in_ready  out  1  unit accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0: A+B, 1: A−B (B inverted, carry-in = 1)
- signed_mode  in  1  1: two's-complement saturation/overflow semantics
- sat  in  1  1: clamp on overflow instead of wrapping
- out_valid  out  1  result beat present
- out_ready  in  1  consumer takes the beat this cycle
- result  out  WIDTH  final (possibly saturated) result
- cout  out  1  raw carry out of MSB (SUB: 1 = no borrow)
- ovf  out  1  raw signed overflow, independent of signed_mode
- zero  out  1  result == 0
- neg  out  1  result[WIDTH−1]

## Operation
- Transfer on either side occurs when valid && ready in the same cycle.
- Stage 1 (S1):
  - e = b XOR {WIDTH{sub}}.
  - Low sum = a[LO−1:0] + e[LO−1:0] + sub. Register low sum, carry c_lo, a/e upper halves, a[MSB], e[MSB], sub, signed_mode, sat.
- Stage 2 (S2):
  - Upper sum = a_hi + e_hi + c_lo. Raw = {upper, low}. cout = upper carry-out.
  - ovf = (a[MSB] == e[MSB]) && (raw[MSB] != a[MSB]).
- Saturation (sat=1), applied in S2; otherwise result = raw:
  - signed_mode=1, ovf=1: result = a[MSB] ? 1 followed by zeros (min) : 0 followed by ones (max).
  - signed_mode=0, sub=0, cout=1: result = all ones.
  - signed_mode=0, sub=1, cout=0: result = 0.
- Flags:
  - cout and ovf always report the raw arithmetic.
  - zero and neg are computed from the final result.
- Handshake:
  - s2_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_adv (combinational, no dependence on in_valid).
  - S1 loads when in_ready; S2 loads from S1 when s2_adv.
- Output stability: while out_valid && !out_ready, result and flags hold stable.

## Timing
- Latency: 2 cycles from accepted input to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Reset (rst_n low, asynchronous): s1_valid = out_valid = 0; result, cout, ovf, zero, neg = 0; in_ready = 1. Datapath registers clear.
- Reset mid-operation: all in-flight beats are discarded, with no output after release. The first accepted beat after release appears exactly 2 cycles later.
- Full pipeline under a stall (out_ready = 0, both stages valid): in_ready = 0. No beat is dropped or duplicated.
- Simultaneous pop and push: S2 output leaves, S1 moves to S2 and a new beat enters S1 in the same cycle.
- Wrap-around: sat=0 results wrap modulo 2^WIDTH.
- Mode inputs (sub, signed_mode, sat) are sampled per beat with the operands and may change every cycle.

## Structure
- Package addsub_pkg: WIDTH-derived LO/HI helper functions, sat_max(signed) and sat_min(signed) constant functions.
- Sub-module addsub_slice (parameter N): N-bit ripple adder with cin, sum, cout. It is instantiated twice, for the LO and HI slices.
- Top level holds the S1/S2 registers, handshake logic, saturation mux and flag logic.

## Test plan
- WIDTH=8, sub=1, a=0x05, b=0x03, out_ready=1 → two cycles later result=0x02, cout=1, ovf=0, zero=0.
- WIDTH=8, signed_mode=1, sat=1, sub=0, a=0x70, b=0x20 → ovf=1, result=0x7F, neg=0. Same with sat=0 → result=0x90, neg=1.
- WIDTH=16, unsigned, sat=1, sub=1, a=0x0003, b=0x0005 → cout=0, result=0x0000, zero=1. Same with sub=0, a=0xFFF0, b=0x0020 → result=0xFFFF, cout=1.
- Backpressure: stream 0..9 (a=i, b=1) with out_ready toggling 1,0,0,1… → exactly 10 outputs in order, 1..10. in_ready drops only when both stages are full; no loss or duplication.
- Assert rst_n low for 1 cycle with both stages valid → out_valid=0 and all outputs 0 immediately. The next accepted beat a=0x0100, b=0x00FF (WIDTH=16, add) gives result 0x01FF after 2 cycles.
- Carry across split: WIDTH=16, a=0x00FF, b=0x0001, add → result=0x0100, cout=0. Also a=0xFFFF, b=0x0001 → result=0x0000, cout=1, zero=1.
